// File: rtl/tnt_rom_pkg.sv
// Shared types and constants for the TNT ROM scanner.
//   state_t : scanner FSM state encoding
//   CKSUM_W : width of the running checksum output
package tnt_rom_pkg;

  localparam int unsigned CKSUM_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tnt_rom_cksum.sv
// Checksum accumulator for accepted scan words.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the sum (start of a new scan), has priority over en
//   en         : add din to the sum this cycle
//   din        : word to accumulate, zero-extended
//   sum        : running sum modulo 2^CKSUM_W
module tnt_rom_cksum
  import tnt_rom_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DATA_W-1:0]  din,
  output logic [CKSUM_W-1:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + CKSUM_W'(din);
    end
  end

endmodule

// File: rtl/tnt_rom_scanner.sv
// Sequential ROM scanner: reads len+1 words starting at base_addr (address
// wraps modulo 2^ADDR_W), one outstanding read at a time, and hands each word
// to a consumer over a valid/ready handshake.
//   start, abort          : scan request (IDLE only) / synchronous cancel
//   base_addr, len        : first address and word count minus 1
//   rom_en, rom_addr      : read strobe/address, RD_LAT-cycle ROM latency
//   rom_data              : ROM read data
//   out_data, out_valid   : scanned word and its valid flag
//   out_ready             : consumer accepts the word
//   busy, done, checksum  : non-IDLE flag, completion pulse, running sum
// Macro TNT_ROM_CHECKSUM_EN builds the checksum accumulator; without it
// checksum is tied to 0.
module tnt_rom_scanner
  import tnt_rom_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  len,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [CKSUM_W-1:0] checksum
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   rem_q;
  logic [1:0]          wait_q;
  logic [DATA_W-1:0]   data_q;
  logic                accept;
  logic                handshake;
  logic                wait_last;

  // abort beats a simultaneous start in IDLE
  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign handshake = (state_q == ST_OUT) && out_ready && !abort;
  assign wait_last = (wait_q == 2'(RD_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (wait_last) state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = (rem_q == '0) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      wait_q <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= base_addr;
        rem_q  <= len;
      end
      if (state_q == ST_ISSUE) begin
        wait_q <= '0;
      end
      if (state_q == ST_WAIT) begin
        wait_q <= wait_q + 2'd1;
        if (wait_last) data_q <= rom_data;
      end
      if (handshake && (rem_q != '0)) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end
    end
  end

  assign rom_en    = (state_q == ST_ISSUE);
  assign rom_addr  = rom_en ? addr_q : '0;
  assign out_data  = data_q;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

`ifdef TNT_ROM_CHECKSUM_EN
  tnt_rom_cksum #(
    .DATA_W(DATA_W)
  ) u_cksum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (handshake),
    .din  (data_q),
    .sum  (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_tnt_rom_scanner.sv
// Self-checking bench for tnt_rom_scanner with ROM model rom[a] = a ^ 0x5A.
// Two instances: RD_LAT=1 (main) and RD_LAT=3 (latency check).
module tb_tnt_rom_scanner;

`ifdef TNT_ROM_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort, out_ready;
  logic [7:0]  base_addr, len;
  logic        rom_en, out_valid, busy, done;
  logic [7:0]  rom_addr, rom_data, out_data;
  logic [15:0] checksum;

  logic        start3, abort3, ready3;
  logic [7:0]  base3, len3;
  logic        rom_en3, valid3, busy3, done3;
  logic [7:0]  rom_addr3, rom_data3, out_data3;
  logic [15:0] checksum3;

  tnt_rom_scanner #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .len(len), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .checksum(checksum)
  );

  tnt_rom_scanner #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .base_addr(base3), .len(len3), .rom_en(rom_en3), .rom_addr(rom_addr3),
    .rom_data(rom_data3), .out_data(out_data3), .out_valid(valid3),
    .out_ready(ready3), .busy(busy3), .done(done3), .checksum(checksum3)
  );

  // ROM models: fixed-latency pipelines
  logic [7:0] pipe1;
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    pipe1 <= rom_addr ^ 8'h5A;
    p3[0] <= rom_addr3 ^ 8'h5A;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rom_data  = pipe1;
  assign rom_data3 = p3[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // scoreboards
  logic [7:0] q_data[$];
  logic [7:0] q_addr[$];
  logic [7:0] q3[$];
  int   done_cnt = 0, done3_cnt = 0;
  int   en_cyc = 0, en3_cyc = 0;
  logic vprev = 1'b0, vprev3 = 1'b0;
  logic first_pending = 1'b0;
  logic [7:0] first_word = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        if (q_addr.size() == 0) fail("rom_addr_unexpected");
        else check("rom_addr", rom_addr, q_addr.pop_front());
        en_cyc = cyc;
      end
      if (out_valid && !vprev) check("latency_lat1", cyc - en_cyc, 2);
      if (out_valid && out_ready) begin
        if (first_pending) begin
          first_word    = out_data;
          first_pending = 1'b0;
        end
        if (q_data.size() == 0) fail("word_unexpected");
        else check("out_data", out_data, q_data.pop_front());
      end
      if (done) done_cnt++;
      if (rom_en3) en3_cyc = cyc;
      if (valid3 && !vprev3) check("latency_lat3", cyc - en3_cyc, 4);
      if (valid3 && ready3) begin
        if (q3.size() == 0) fail("word3_unexpected");
        else check("out_data3", out_data3, q3.pop_front());
      end
      if (done3) done3_cnt++;
    end
    vprev  = out_valid;
    vprev3 = valid3;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail({tag, "_timeout"});
  endtask

  task automatic run_scan(input logic [7:0] b, input logic [7:0] l,
                          input logic [7:0] exp_first, input logic [15:0] exp_sum,
                          input string tag);
    int d0;
    for (int i = 0; i <= int'(l); i++) begin
      logic [7:0] a;
      a = b + 8'(i);
      q_addr.push_back(a);
      q_data.push_back(a ^ 8'h5A);
    end
    d0 = done_cnt;
    first_pending = 1'b1;
    base_addr = b;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_idle(tag);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_first_word"}, first_word, exp_first);
    check({tag, "_checksum"}, checksum, CK_ON ? exp_sum : 16'h0);
    check({tag, "_left_words"}, q_data.size(), 0);
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  len;
    logic [7:0]  exp_first;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [7:0] hold;
    int n;

    vecs[0] = '{8'h10, 8'h03, 8'h4A, 16'h0126};
    vecs[1] = '{8'hFE, 8'h02, 8'hA4, 16'h01A3};
    vecs[2] = '{8'h00, 8'h00, 8'h5A, 16'h005A};
    vecs[3] = '{8'hFF, 8'h01, 8'hA5, 16'h00FF};
    vecs[4] = '{8'h80, 8'h07, 8'hDA, 16'h06DC};

    rst_n = 1'b0; start = 0; abort = 0; out_ready = 1; base_addr = 0; len = 0;
    start3 = 0; abort3 = 0; ready3 = 1; base3 = 0; len3 = 0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_rom_en", rom_en, 0);
    check("reset_checksum", checksum, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_scan(vecs[i].base, vecs[i].len, vecs[i].exp_first,
                               vecs[i].exp_sum, $sformatf("vec%0d", i));

    // consumer stall in OUT
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q_addr.push_back(8'h40 + 8'(i));
      q_data.push_back((8'h40 + 8'(i)) ^ 8'h5A);
    end
    d0 = done_cnt;
    base_addr = 8'h40; len = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("stall_reached_out", out_valid, 1);
    hold = out_data;
    check("stall_word", hold, 8'h1A);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data_stable", out_data, hold);
      check("stall_rom_en", rom_en, 0);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_idle("stall");
    check("stall_done", done_cnt - d0, 1);
    check("stall_left_words", q_data.size(), 0);

    // ignored mid-scan start, then abort on the second word
    for (int i = 0; i < 4; i++) begin
      q_addr.push_back(8'h20 + 8'(i));
      q_data.push_back((8'h20 + 8'(i)) ^ 8'h5A);
    end
    d0 = done_cnt;
    base_addr = 8'h20; len = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    base_addr = 8'h90; len = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_data == 8'h7B) && n < 20) begin tick(); n++; end
    check("abort_second_word", out_data, 8'h7B);
    abort = 1'b1; out_ready = 1'b0;
    tick();
    abort = 1'b0; out_ready = 1'b1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    repeat (4) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_stays_idle", busy, 0);
    q_data.delete();
    q_addr.delete();

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; base_addr = 8'h00; len = 8'h00;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);

    // reset mid-burst
    for (int i = 0; i < 4; i++) begin
      q_addr.push_back(8'h30 + 8'(i));
      q_data.push_back((8'h30 + 8'(i)) ^ 8'h5A);
    end
    base_addr = 8'h30; len = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom", {rom_en, rom_addr}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_checksum", checksum, 0);
    q_data.delete();
    q_addr.delete();
    tick();
    rst_n = 1'b1;
    run_scan(8'h10, 8'h03, 8'h4A, 16'h0126, "post_rst");

    // RD_LAT=3 instance
    q3.push_back(8'h4A);
    q3.push_back(8'h4B);
    d0 = done3_cnt;
    base3 = 8'h10; len3 = 8'h01; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (busy3 && n < 100) begin tick(); n++; end
    check("lat3_idle", busy3, 0);
    check("lat3_done", done3_cnt - d0, 1);
    check("lat3_left_words", q3.size(), 0);
    check("lat3_checksum", checksum3, CK_ON ? 16'h0095 : 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
